// File: rtl/mem_arbiter.sv
// mem_arbiter
// Single-port RAM arbiter between instruction fetch (imem) and load/store
// (dmem). dmem wins ties, but after MAX_DSTREAK back-to-back dmem grants
// with an imem request pending, one imem grant is forced. A per-grant
// watchdog aborts transactions the RAM never acknowledges.
//
// Ports:
//   CLK, nRST            clock (rising edge), synchronous active-high reset
//   iREN, iaddr          instruction read request / word address
//   iload, iwait         instruction read data / 1 while not complete
//   dREN, dWEN           data read / write request (never both high)
//   daddr, dstore        data address / write value
//   dload, dwait         data read value / 1 while not complete
//   ramREN, ramWEN       RAM read / write enable
//   ramaddr, ramstore    RAM address / write data
//   ramload, ramstate    RAM read data / status (FREE, BUSY, ACCESS, ERROR)
//   arb_err              sticky flag: a transaction timed out or saw ERROR
module mem_arbiter #(
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        arb_err
);

  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam int SW = $clog2(MAX_DSTREAK + 1);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] dstreak;

  logic dreq;
  logic access;
  logic finish;
  logic granted_req;
  logic complete;
  logic fault;

  assign dreq   = dREN | dWEN;
  assign access = (ramstate == RAM_ACCESS);
  // Anything that ends a live grant: acknowledge, RAM error or watchdog.
  assign finish = access || (ramstate == RAM_ERROR) || (tcnt == TW'(TIMEOUT));

  // Next state and all outputs. Non-granted waits simply mirror their
  // request, so they never depend on ramstate.
  always_comb begin
    next_state  = state;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = 32'd0;
    ramstore    = 32'd0;
    iload       = 32'd0;
    dload       = 32'd0;
    iwait       = iREN;
    dwait       = dreq;
    granted_req = 1'b0;

    case (state)
      IDLE: begin
        if (dreq && ((dstreak < SW'(MAX_DSTREAK)) || !iREN)) begin
          next_state = DGRANT;
        end else if (iREN) begin
          next_state = IGRANT;
        end
      end
      DGRANT: begin
        granted_req = dreq;
        ramREN      = dREN;
        ramWEN      = dWEN;
        ramaddr     = daddr;
        ramstore    = dstore;
        dload       = ramload;
        // A dropped request aborts silently: wait stays high, no pulse.
        dwait       = !(dreq && finish);
        if (!dreq || finish) begin
          next_state = IDLE;
        end
      end
      IGRANT: begin
        granted_req = iREN;
        ramREN      = iREN;
        ramaddr     = iaddr;
        iload       = ramload;
        iwait       = !(iREN && finish);
        if (!iREN || finish) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // An acknowledge takes precedence over a coincident watchdog expiry.
  assign complete = granted_req && access;
  assign fault    = granted_req && !access && finish;

  // State register, watchdog counter, starvation streak and error flag.
  // tcnt is cleared while idle, which covers every entry into a grant.
  always_ff @(posedge CLK) begin
    if (nRST) begin
      state   <= IDLE;
      tcnt    <= '0;
      dstreak <= '0;
      arb_err <= 1'b0;
    end else begin
      state <= next_state;

      if (state == IDLE) begin
        tcnt <= '0;
      end else if (!access) begin
        tcnt <= tcnt + TW'(1);
      end

      if (fault) begin
        arb_err <= 1'b1;
      end

      if ((state == DGRANT) && complete && iREN) begin
        if (dstreak != SW'(MAX_DSTREAK)) begin
          dstreak <= dstreak + SW'(1);
        end
      end else if ((state == IGRANT) && complete) begin
        dstreak <= '0;
      end else if ((state == IDLE) && !iREN) begin
        dstreak <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: a vector table for the basic
// imem/dmem flows, hand-written sequences for starvation, timeout, abort,
// error and reset, then randomized traffic against a behavioural model.
module tb_mem_arbiter;

  localparam int MAXD = 4;
  localparam int TMO  = 8;

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        arb_err;

  always #5 CLK = ~CLK;

  mem_arbiter #(.MAX_DSTREAK(MAXD), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
  );

  typedef struct {
    logic        iren, dren, dwen;
    logic [31:0] ia, da, ds, rl;
    logic [1:0]  rs;
  } ins_t;

  typedef struct {
    logic        ren, wen;
    logic [31:0] addr, store;
    logic        iw, dw;
    logic [31:0] il, dl;
    logic        err;
  } outs_t;

  typedef struct {
    ins_t  in;
    outs_t exp;
  } vec_t;

  int checks = 0;
  int passes = 0;

  // Behavioural model: who owns the RAM (0 none, 1 data, 2 instruction),
  // how long the current grant has gone unacknowledged, the dmem streak.
  int   m_owner = 0;
  int   m_age   = 0;
  int   m_streak = 0;
  logic m_err   = 1'b0;

  function automatic ins_t mkIn(logic iren, logic dren, logic dwen,
                                logic [31:0] ia, logic [31:0] da,
                                logic [31:0] ds, logic [31:0] rl,
                                logic [1:0] rs);
    ins_t s;
    s.iren = iren; s.dren = dren; s.dwen = dwen;
    s.ia = ia; s.da = da; s.ds = ds; s.rl = rl; s.rs = rs;
    return s;
  endfunction

  function automatic outs_t mkOut(logic ren, logic wen, logic [31:0] addr,
                                  logic [31:0] store, logic iw, logic dw,
                                  logic [31:0] il, logic [31:0] dl,
                                  logic err);
    outs_t o;
    o.ren = ren; o.wen = wen; o.addr = addr; o.store = store;
    o.iw = iw; o.dw = dw; o.il = il; o.dl = dl; o.err = err;
    return o;
  endfunction

  function automatic outs_t idleOuts(logic iw, logic dw, logic err);
    return mkOut(1'b0, 1'b0, 32'd0, 32'd0, iw, dw, 32'd0, 32'd0, err);
  endfunction

  function automatic outs_t modelOuts(ins_t s);
    outs_t o;
    logic  dreq;
    logic  ends;
    dreq = s.dren | s.dwen;
    ends = (s.rs == RS_ACCESS) || (s.rs == RS_ERROR) || (m_age == TMO);
    o = idleOuts(s.iren, dreq, m_err);
    if (m_owner == 1) begin
      o.ren = s.dren; o.wen = s.dwen; o.addr = s.da; o.store = s.ds;
      o.dl = s.rl;
      o.dw = !(dreq && ends);
    end else if (m_owner == 2) begin
      o.ren = s.iren; o.addr = s.ia; o.il = s.rl;
      o.iw = !(s.iren && ends);
    end
    return o;
  endfunction

  task automatic modelAdvance(input ins_t s, input logic rst);
    logic dreq;
    logic req;
    dreq = s.dren | s.dwen;
    if (rst) begin
      m_owner = 0; m_age = 0; m_streak = 0; m_err = 1'b0;
      return;
    end
    if (m_owner == 0) begin
      if (!s.iren) m_streak = 0;
      if (dreq && (m_streak < MAXD || !s.iren)) begin
        m_owner = 1; m_age = 0;
      end else if (s.iren) begin
        m_owner = 2; m_age = 0;
      end
    end else begin
      req = (m_owner == 1) ? dreq : s.iren;
      if (!req) begin
        m_owner = 0;
      end else if (s.rs == RS_ACCESS) begin
        if (m_owner == 1) begin
          if (s.iren && m_streak < MAXD) m_streak = m_streak + 1;
        end else begin
          m_streak = 0;
        end
        m_owner = 0;
      end else if (s.rs == RS_ERROR || m_age == TMO) begin
        m_err = 1'b1;
        m_owner = 0;
      end else begin
        m_age = m_age + 1;
      end
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Inputs are driven 1 time unit after a rising edge and outputs are
  // sampled 2 units later, well clear of both edges.
  task automatic applyStimulus(input ins_t s);
    iREN = s.iren; dREN = s.dren; dWEN = s.dwen;
    iaddr = s.ia; daddr = s.da; dstore = s.ds;
    ramload = s.rl; ramstate = s.rs;
    #2;
  endtask

  task automatic checkOutput(input string tag, input outs_t e);
    checkVal({tag, ".ramREN"},   32'(ramREN),   32'(e.ren));
    checkVal({tag, ".ramWEN"},   32'(ramWEN),   32'(e.wen));
    checkVal({tag, ".ramaddr"},  ramaddr,       e.addr);
    checkVal({tag, ".ramstore"}, ramstore,      e.store);
    checkVal({tag, ".iwait"},    32'(iwait),    32'(e.iw));
    checkVal({tag, ".dwait"},    32'(dwait),    32'(e.dw));
    checkVal({tag, ".iload"},    iload,         e.il);
    checkVal({tag, ".dload"},    dload,         e.dl);
    checkVal({tag, ".arb_err"},  32'(arb_err),  32'(e.err));
  endtask

  task automatic nextCycle;
    @(posedge CLK);
    #1;
  endtask

  task automatic runCheck(input string tag, input ins_t s, input outs_t e);
    applyStimulus(s);
    checkOutput(tag, e);
    nextCycle();
  endtask

  task automatic doReset;
    ins_t z;
    z = mkIn(0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, RS_FREE);
    nRST = 1'b1;
    applyStimulus(z);
    nextCycle();
    nRST = 1'b0;
    modelAdvance(z, 1'b1);
    runCheck("reset", z, idleOuts(0, 0, 0));
  endtask

  initial begin
    vec_t  tbl[11];
    ins_t  s;
    ins_t  r;
    outs_t e;
    logic  rst;
    int    sel;

    nRST = 1'b1;
    applyStimulus(mkIn(0, 0, 0, 32'd0, 32'd0, 32'd0, 32'd0, RS_FREE));
    @(posedge CLK);
    #1;
    doReset();

    // Lone imem read, then simultaneous dmem write + imem read.
    tbl[0].in  = mkIn(1, 0, 0, 32'h40, 0, 0, 32'hAAAA0000, RS_FREE);
    tbl[0].exp = idleOuts(1, 0, 0);
    tbl[1].in  = mkIn(1, 0, 0, 32'h40, 0, 0, 32'hAAAA0000, RS_FREE);
    tbl[1].exp = mkOut(1, 0, 32'h40, 0, 1, 0, 32'hAAAA0000, 0, 0);
    tbl[2].in  = mkIn(1, 0, 0, 32'h40, 0, 0, 32'hBBBB0000, RS_BUSY);
    tbl[2].exp = mkOut(1, 0, 32'h40, 0, 1, 0, 32'hBBBB0000, 0, 0);
    tbl[3].in  = tbl[2].in;
    tbl[3].exp = tbl[2].exp;
    tbl[4].in  = mkIn(1, 0, 0, 32'h40, 0, 0, 32'h8C220004, RS_ACCESS);
    tbl[4].exp = mkOut(1, 0, 32'h40, 0, 0, 0, 32'h8C220004, 0, 0);
    tbl[5].in  = mkIn(0, 0, 0, 32'h40, 0, 0, 32'h8C220004, RS_FREE);
    tbl[5].exp = idleOuts(0, 0, 0);
    tbl[6].in  = mkIn(1, 0, 1, 32'h40, 32'h100, 32'hDEADBEEF, 32'h12345678, RS_FREE);
    tbl[6].exp = idleOuts(1, 1, 0);
    tbl[7].in  = mkIn(1, 0, 1, 32'h40, 32'h100, 32'hDEADBEEF, 32'h12345678, RS_ACCESS);
    tbl[7].exp = mkOut(0, 1, 32'h100, 32'hDEADBEEF, 1, 0, 0, 32'h12345678, 0);
    tbl[8].in  = mkIn(1, 0, 0, 32'h40, 32'h100, 32'hDEADBEEF, 32'h12345678, RS_FREE);
    tbl[8].exp = idleOuts(1, 0, 0);
    tbl[9].in  = mkIn(1, 0, 0, 32'h40, 32'h100, 32'hDEADBEEF, 32'hCAFEF00D, RS_ACCESS);
    tbl[9].exp = mkOut(1, 0, 32'h40, 0, 0, 0, 32'hCAFEF00D, 0, 0);
    tbl[10].in  = mkIn(0, 0, 0, 0, 0, 0, 0, RS_FREE);
    tbl[10].exp = idleOuts(0, 0, 0);

    for (int i = 0; i < 11; i++) begin
      runCheck($sformatf("vec%0d", i), tbl[i].in, tbl[i].exp);
    end

    // Starvation: both held, RAM always ready -> DDDDI DDDDI.
    doReset();
    s = mkIn(1, 1, 0, 32'h80, 32'h200, 32'h77, 32'h5555AAAA, RS_ACCESS);
    for (int g = 0; g < 10; g++) begin
      runCheck($sformatf("starve%0d.idle", g), s, idleOuts(1, 1, 0));
      if (g % 5 == 4)
        e = mkOut(1, 0, 32'h80, 0, 0, 1, 32'h5555AAAA, 0, 0);
      else
        e = mkOut(1, 0, 32'h200, 32'h77, 1, 0, 0, 32'h5555AAAA, 0);
      runCheck($sformatf("starve%0d.grant", g), s, e);
    end

    // Timeout: RAM stuck BUSY; the 9th grant cycle releases with arb_err.
    doReset();
    s = mkIn(0, 1, 0, 0, 32'h300, 32'h9, 32'h1234, RS_BUSY);
    runCheck("tmo.idle", s, idleOuts(0, 1, 0));
    for (int k = 1; k <= 9; k++) begin
      e = mkOut(1, 0, 32'h300, 32'h9, 0, (k == 9) ? 1'b0 : 1'b1, 0, 32'h1234, 0);
      runCheck($sformatf("tmo.grant%0d", k), s, e);
    end
    s.dren = 1'b0;
    for (int k = 0; k < 3; k++) begin
      runCheck($sformatf("tmo.after%0d", k), s, idleOuts(0, 0, 1));
    end

    // Reset during IGRANT with arb_err set: everything back to reset values.
    s = mkIn(1, 0, 0, 32'h500, 0, 0, 32'h4321, RS_BUSY);
    runCheck("rstig.idle", s, idleOuts(1, 0, 1));
    runCheck("rstig.grant", s, mkOut(1, 0, 32'h500, 0, 1, 0, 32'h4321, 0, 1));
    nRST = 1'b1;
    applyStimulus(s);
    nextCycle();
    nRST = 1'b0;
    applyStimulus(s);
    checkOutput("rstig.after", idleOuts(1, 0, 0));
    doReset();

    // dREN drops mid-grant: no wait-low pulse, back to IDLE.
    s = mkIn(0, 1, 0, 0, 32'h400, 32'h55, 32'h6666, RS_BUSY);
    runCheck("abort.idle", s, idleOuts(0, 1, 0));
    runCheck("abort.grant", s, mkOut(1, 0, 32'h400, 32'h55, 0, 1, 0, 32'h6666, 0));
    s.dren = 1'b0;
    runCheck("abort.drop", s, mkOut(0, 0, 32'h400, 32'h55, 0, 1, 0, 32'h6666, 0));
    s.dren = 1'b1;
    runCheck("abort.after", s, idleOuts(0, 1, 0));
    doReset();

    // RAM ERROR during an imem grant.
    s = mkIn(1, 0, 0, 32'h600, 0, 0, 32'h7, RS_FREE);
    runCheck("err.idle", s, idleOuts(1, 0, 0));
    s.rs = RS_ERROR;
    runCheck("err.grant", s, mkOut(1, 0, 32'h600, 0, 0, 0, 32'h7, 0, 0));
    s.iren = 1'b0;
    runCheck("err.after", s, idleOuts(0, 0, 1));

    // Randomized traffic against the behavioural model.
    doReset();
    r = mkIn(0, 0, 0, 0, 0, 0, 0, RS_FREE);
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 4) == 0) r.iren = ~r.iren;
      if ($urandom_range(0, 4) == 0) begin
        sel = int'($urandom_range(0, 2));
        r.dren = (sel == 1);
        r.dwen = (sel == 2);
      end
      r.ia = $urandom; r.da = $urandom; r.ds = $urandom; r.rl = $urandom;
      sel = int'($urandom_range(0, 99));
      r.rs = (sel < 25) ? RS_FREE : (sel < 60) ? RS_BUSY :
             (sel < 88) ? RS_ACCESS : RS_ERROR;
      rst = ($urandom_range(0, 99) == 0);
      nRST = rst;
      applyStimulus(r);
      checkOutput($sformatf("rand%0d", n), modelOuts(r));
      modelAdvance(r, rst);
      nextCycle();
      nRST = 1'b0;
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
